// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
//
// Purpose:
//   SPI master, mode 0 (CPOL=0, CPHA=0). Divides i_clk by the latched
//   i_factor to generate SCLK, then shifts one DATA_W-bit word out on MOSI
//   while capturing MISO. The controlling logic uses a START/BUSY/DONE
//   handshake.
//
// Configuration macro:
//   SPI_LSB_FIRST_EN - when defined, TX_DATA[0] is sent first and the first
//                      received bit lands in RX_DATA[0]. Default is MSB first.
//
// Ports:
//   i_clk      in   1       system clock, all logic on posedge
//   i_rst      in   1       synchronous active-high reset
//   i_factor   in   DIV_W   SCLK half-period in clock cycles (0 acts as 1)
//   i_start    in   1       transfer request, honoured only in IDLE
//   i_tx_data  in   DATA_W  word to send, latched with i_start
//   i_miso     in   1       serial data from slave
//   o_sclk     out  1       SPI clock, idle low
//   o_mosi     out  1       serial data to slave
//   o_cs_n     out  1       slave select, active low
//   o_busy     out  1       transfer in progress
//   o_done     out  1       one-cycle pulse, o_rx_data valid
//   o_rx_data  out  DATA_W  last received word, held until next o_done
// -----------------------------------------------------------------------------
module spi_master_shifter #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DIV_W-1:0]  i_factor,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_miso,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic              o_cs_n,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rx_data
);

   localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W - 1);
   localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_END   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Bit the shifter drives first for a freshly latched word.
   function automatic logic f_first_bit(input logic [DATA_W-1:0] word);
`ifdef SPI_LSB_FIRST_EN
      return word[0];
`else
      return word[DATA_W-1];
`endif
   endfunction

   // Bit that follows the current MOSI bit in the not-yet-shifted word.
   function automatic logic f_next_bit(input logic [DATA_W-1:0] word);
`ifdef SPI_LSB_FIRST_EN
      return word[1];
`else
      return word[DATA_W-2];
`endif
   endfunction

   // Discard the bit just sent.
   function automatic logic [DATA_W-1:0] f_shift_tx(input logic [DATA_W-1:0] word);
`ifdef SPI_LSB_FIRST_EN
      return {1'b0, word[DATA_W-1:1]};
`else
      return {word[DATA_W-2:0], 1'b0};
`endif
   endfunction

   // Insert a received bit so the first bit ends at the first-sent position.
   function automatic logic [DATA_W-1:0] f_shift_rx(input logic [DATA_W-1:0] word,
                                                    input logic           bit_in);
`ifdef SPI_LSB_FIRST_EN
      return {bit_in, word[DATA_W-1:1]};
`else
      return {word[DATA_W-2:0], bit_in};
`endif
   endfunction

   state_t              r_state;
   logic [DIV_W-1:0]    r_f;
   logic [DIV_W-1:0]    r_hc;
   logic [BC_W-1:0]     r_bit_cnt;
   logic                r_end_half;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic                r_sclk;
   logic                r_mosi;
   logic                r_cs_n;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_rx_data;

   state_t              w_state;
   logic [DIV_W-1:0]    w_f;
   logic [DIV_W-1:0]    w_hc;
   logic [DIV_W-1:0]    w_hc_adv;
   logic                w_tick;
   logic [BC_W-1:0]     w_bit_cnt;
   logic                w_end_half;
   logic [DATA_W-1:0]   w_tx;
   logic [DATA_W-1:0]   w_rx;
   logic                w_sclk;
   logic                w_mosi;
   logic                w_cs_n;
   logic                w_busy;
   logic                w_done;
   logic [DATA_W-1:0]   w_rx_data;

   // Half-period tick and the counter value that follows it.
   always_comb begin
      w_tick   = (r_hc == (r_f - DIV_ONE));
      w_hc_adv = w_tick ? {DIV_W{1'b0}} : (r_hc + DIV_ONE);
   end

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      w_state    = r_state;
      w_f        = r_f;
      w_hc       = r_hc;
      w_bit_cnt  = r_bit_cnt;
      w_end_half = r_end_half;
      w_tx       = r_tx;
      w_rx       = r_rx;
      w_sclk     = r_sclk;
      w_mosi     = r_mosi;
      w_cs_n     = r_cs_n;
      w_busy     = r_busy;
      w_done     = 1'b0;
      w_rx_data  = r_rx_data;

      case (r_state)
         S_IDLE: begin
            w_hc   = {DIV_W{1'b0}};
            w_sclk = 1'b0;
            w_cs_n = 1'b1;
            w_busy = 1'b0;
            w_mosi = 1'b0;
            if (i_start) begin
               w_state    = S_SETUP;
               w_f        = (i_factor == {DIV_W{1'b0}}) ? DIV_ONE : i_factor;
               w_bit_cnt  = {BC_W{1'b0}};
               w_end_half = 1'b0;
               w_tx       = i_tx_data;
               w_rx       = {DATA_W{1'b0}};
               w_mosi     = f_first_bit(i_tx_data);
               w_cs_n     = 1'b0;
               w_busy     = 1'b1;
            end else begin
               w_state = S_IDLE;
            end
         end

         S_SETUP: begin
            w_hc = w_hc_adv;
            // First rising edge: slave sees the first bit, master samples MISO.
            if (w_tick) begin
               w_state = S_SHIFT;
               w_sclk  = 1'b1;
               w_rx    = f_shift_rx(r_rx, i_miso);
            end else begin
               w_state = S_SETUP;
            end
         end

         S_SHIFT: begin
            w_hc = w_hc_adv;
            if (w_tick) begin
               if (r_sclk) begin
                  // Falling edge: present the next bit unless the word is done.
                  w_sclk = 1'b0;
                  if (r_bit_cnt == BC_LAST) begin
                     w_state    = S_END;
                     w_end_half = 1'b0;
                  end else begin
                     w_bit_cnt = r_bit_cnt + BC_ONE;
                     w_tx      = f_shift_tx(r_tx);
                     w_mosi    = f_next_bit(r_tx);
                  end
               end else begin
                  // Rising edge: capture MISO.
                  w_sclk = 1'b1;
                  w_rx   = f_shift_rx(r_rx, i_miso);
               end
            end else begin
               w_state = S_SHIFT;
            end
         end

         S_END: begin
            w_hc = w_hc_adv;
            // Trailing guard of two half-periods with SCLK low and MOSI held.
            if (w_tick) begin
               if (r_end_half) begin
                  w_state   = S_DONE;
                  w_hc      = {DIV_W{1'b0}};
                  w_rx_data = r_rx;
                  w_cs_n    = 1'b1;
                  w_busy    = 1'b0;
                  w_done    = 1'b1;
                  w_mosi    = 1'b0;
               end else begin
                  w_end_half = 1'b1;
               end
            end else begin
               w_state = S_END;
            end
         end

         S_DONE: begin
            // START is deliberately not looked at here.
            w_state = S_IDLE;
            w_hc    = {DIV_W{1'b0}};
         end

         default: begin
            w_state = S_IDLE;
            w_hc    = {DIV_W{1'b0}};
            w_sclk  = 1'b0;
            w_mosi  = 1'b0;
            w_cs_n  = 1'b1;
            w_busy  = 1'b0;
         end
      endcase
   end

   // State and registered outputs, synchronous reset aborts any transfer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_f        <= DIV_ONE;
         r_hc       <= {DIV_W{1'b0}};
         r_bit_cnt  <= {BC_W{1'b0}};
         r_end_half <= 1'b0;
         r_tx       <= {DATA_W{1'b0}};
         r_rx       <= {DATA_W{1'b0}};
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rx_data  <= {DATA_W{1'b0}};
      end else begin
         r_state    <= w_state;
         r_f        <= w_f;
         r_hc       <= w_hc;
         r_bit_cnt  <= w_bit_cnt;
         r_end_half <= w_end_half;
         r_tx       <= w_tx;
         r_rx       <= w_rx;
         r_sclk     <= w_sclk;
         r_mosi     <= w_mosi;
         r_cs_n     <= w_cs_n;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_rx_data  <= w_rx_data;
      end
   end

   assign o_sclk    = r_sclk;
   assign o_mosi    = r_mosi;
   assign o_cs_n    = r_cs_n;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_shifter
//
// Directed self-checking bench for spi_master_shifter (DATA_W=8, DIV_W=32).
// START is driven just after edge k so the DUT samples it at edge k+1; DONE
// is expected to be seen high right after edge k+1+F*18.
// -----------------------------------------------------------------------------
module tb_spi_master_shifter;

   logic        clk;
   logic        rst;
   logic [31:0] factor;
   logic        start;
   logic [7:0]  tx_data;
   logic        miso;
   logic        sclk;
   logic        mosi;
   logic        cs_n;
   logic        busy;
   logic        done;
   logic [7:0]  rx_data;

   logic        loop_en;
   logic        miso_val;
   int          cyc;
   int          total;
   int          bad;

   assign miso = loop_en ? mosi : miso_val;

   spi_master_shifter #(.DATA_W(8), .DIV_W(32)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_factor  (factor),
      .i_start   (start),
      .i_tx_data (tx_data),
      .i_miso    (miso),
      .o_sclk    (sclk),
      .o_mosi    (mosi),
      .o_cs_n    (cs_n),
      .o_busy    (busy),
      .o_done    (done),
      .o_rx_data (rx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transfer. mmode: 0 loopback, 1 MISO tied high, 2 MISO from pat
   // (pat[7] is the first bit on the wire). exp_bits[7] is the first MOSI bit.
   // abort_rise != 0 applies a reset right after that SCLK rise.
   task automatic xfer(input string tag, input logic [31:0] fac, input logic [7:0] tx,
                       input int mmode, input logic [7:0] pat, input int exp_lat,
                       input logic [7:0] exp_rx, input logic [7:0] exp_bits,
                       input int exp_f, input bit disturb, input int abort_rise);
      int k;
      int rises;
      int run;
      int duty_bad;
      int done_cyc;
      int extra;
      bit done_seen;
      logic prev;
      logic [7:0] bits;
      step();
      factor   = fac;
      tx_data  = tx;
      start    = 1'b1;
      loop_en  = (mmode == 0);
      miso_val = (mmode == 1) ? 1'b1 : pat[7];
      k        = cyc;
      step();
      start = 1'b0;
      check({tag, "_cs_low"}, {63'd0, cs_n}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      rises = 0; run = 0; duty_bad = 0; done_seen = 1'b0; done_cyc = 0;
      prev = 1'b0; bits = 8'h00;
      for (int n = 0; n < 400; n++) begin
         if (done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            break;
         end
         if (sclk === prev) begin
            run++;
         end else begin
            if (run != exp_f) duty_bad++;
            if (sclk === 1'b1) begin
               if (rises < 8) bits[7-rises] = mosi;
               rises++;
            end
            run = 1;
         end
         prev = sclk;
         if (mmode == 2 && rises < 8) miso_val = pat[7-rises];
         if (disturb && n == 10) begin
            start  = 1'b1;
            factor = 32'd5;
         end
         if (disturb && n == 11) start = 1'b0;
         if (abort_rise != 0 && rises == abort_rise) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            check({tag, "_abort_cs"}, {63'd0, cs_n}, 64'd1);
            check({tag, "_abort_sclk"}, {63'd0, sclk}, 64'd0);
            check({tag, "_abort_busy"}, {63'd0, busy}, 64'd0);
            check({tag, "_abort_rx"}, {56'd0, rx_data}, 64'd0);
            extra = 0;
            for (int m = 0; m < 60; m++) begin
               if (done === 1'b1) extra++;
               step();
            end
            check({tag, "_abort_nodone"}, 64'(extra), 64'd0);
            return;
         end
         step();
      end
      check({tag, "_done_seen"}, {63'd0, done_seen}, 64'd1);
      check({tag, "_latency"}, 64'(done_cyc - k), 64'(exp_lat));
      check({tag, "_rx"}, {56'd0, rx_data}, {56'd0, exp_rx});
      check({tag, "_rises"}, 64'(rises), 64'd8);
      check({tag, "_mosi_bits"}, {56'd0, bits}, {56'd0, exp_bits});
      check({tag, "_duty"}, 64'(duty_bad), 64'd0);
      check({tag, "_done_cs"}, {63'd0, cs_n}, 64'd1);
      // START raised during the DONE cycle must be ignored.
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
      step();
      check({tag, "_post_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_post_cs"}, {63'd0, cs_n}, 64'd1);
      extra = 0;
      for (int m = 0; m < 40; m++) begin
         if (done === 1'b1) extra++;
         step();
      end
      check({tag, "_single_done"}, 64'(extra), 64'd0);
      check({tag, "_rx_held"}, {56'd0, rx_data}, {56'd0, exp_rx});
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      factor   = 32'd2;
      start    = 1'b0;
      tx_data  = 8'h00;
      loop_en  = 1'b0;
      miso_val = 1'b0;

      // Reset held for three cycles.
      step(); step(); step();
      check("rst_cs_n", {63'd0, cs_n}, 64'd1);
      check("rst_sclk", {63'd0, sclk}, 64'd0);
      check("rst_mosi", {63'd0, mosi}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_rx", {56'd0, rx_data}, 64'd0);
      rst = 1'b0;
      step();

      // F=2, A5 loopback.
      xfer("t2_a5", 32'd2, 8'hA5, 0, 8'h00, 37, 8'hA5, 8'hA5, 2, 1'b0, 0);

      // FACTOR=0 acts as 1, MISO tied high.
      xfer("t3_f0", 32'd0, 8'h3C, 1, 8'h00, 19, 8'hFF, 8'h3C, 1, 1'b0, 0);

      // START pulse and FACTOR change mid-transfer.
      xfer("t4_dist", 32'd2, 8'h5A, 0, 8'h00, 37, 8'h5A, 8'h5A, 2, 1'b1, 0);

      // Receive order with a driven MISO pattern 1,1,0,0,0,0,0,0 at F=3.
`ifdef SPI_LSB_FIRST_EN
      xfer("t_pat", 32'd3, 8'h00, 2, 8'hC0, 55, 8'h03, 8'h00, 3, 1'b0, 0);
`else
      xfer("t_pat", 32'd3, 8'h00, 2, 8'hC0, 55, 8'hC0, 8'h00, 3, 1'b0, 0);
`endif

      // Reset at the 3rd SCLK rise, then a normal transfer.
      xfer("t5_abort", 32'd2, 8'hC3, 0, 8'h00, 37, 8'hC3, 8'hC3, 2, 1'b0, 3);
      xfer("t5_after", 32'd1, 8'h96, 0, 8'h00, 19, 8'h96, 8'h96, 1, 1'b0, 0);

      // Bit order with a single set bit.
`ifdef SPI_LSB_FIRST_EN
      xfer("t6_01", 32'd2, 8'h01, 0, 8'h00, 37, 8'h01, 8'h80, 2, 1'b0, 0);
`else
      xfer("t6_01", 32'd2, 8'h01, 0, 8'h00, 37, 8'h01, 8'h01, 2, 1'b0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
